mux_scan_reg: RTL and testbench
===============================

Name: mux_scan_reg

Overview:
Parametrised, registered N-channel multiplexer; next generation of the team's 8:1 bit mux.
- Selects one DW-bit lane from N_CH packed input lanes.
- Captures the selected lane into an output register with a valid/ready handshake.
- Two modes: manual (external select plus strobe) and auto-scan (internal round-robin pointer).
- Used in the DDCO datapath labs as a channel sampler feeding a serial or display stage.

Parameters:
N_CH, 8, number of input channels (2..64)
DW, 8, data width per channel
SELW, $clog2(N_CH), select/pointer width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  N_CH*DW  packed lanes; lane k = in_data[k*DW +: DW]
mode  in  1  0 = manual, 1 = auto-scan
sel  in  SELW  manual channel select
sel_vld  in  1  manual capture request
out_data  out  DW  registered selected lane
out_ch  out  SELW  channel index of out_data
out_vld  out  1  out_data valid
out_rdy  in  1  downstream accept
sel_err  out  1  one-cycle pulse: manual sel >= N_CH

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n), fixed as decided. While rst_n=0: out_data=0, out_ch=0, out_vld=0, sel_err=0, ptr=0, mode_q=0.
- slot_free = !out_vld || out_rdy. A capture happens only when slot_free.
- Latency: capture condition sampled at edge t; out_vld/out_data are visible after edge t, i.e. one cycle. Throughput is 1 per cycle when out_rdy is held at 1.
- Backpressure: while out_vld && !out_rdy, out_data and out_ch hold stable and no capture occurs. Manual requests arriving then are dropped; the requester must hold sel_vld.
- Manual mode (mode=0):
  - On sel_vld && slot_free && sel < N_CH: out_data <= lane[sel], out_ch <= sel, out_vld <= 1.
  - On sel_vld && slot_free && sel >= N_CH: no capture, sel_err pulses 1 cycle. out_vld is cleared if out_rdy consumed the previous word.
  - No sel_vld && out_rdy: out_vld <= 0.
- Auto-scan mode (mode=1):
  - Every cycle with slot_free: out_data <= lane[ptr], out_ch <= ptr, out_vld <= 1.
  - ptr <= (ptr == N_CH-1) ? 0 : ptr+1.
  - sel and sel_vld are ignored.
- Mode tracking: mode_q registers mode.
  - Entering auto (mode=1, mode_q=0): ptr is forced to 0 for that cycle's capture, so the first auto word is channel 0.
  - Leaving auto: the word in flight completes its handshake normally.
- Pointer arithmetic: SELW-bit, explicit wrap at N_CH-1 (not 2^SELW), so non-power-of-two N_CH never selects an invalid lane.
- Input lanes are sampled combinationally at the capture edge; there is no input register.

Optional Feature:
MUX_SCAN_MASK_EN
- With the macro defined:
  - Adds input port ch_mask [N_CH-1:0], where 1 = channel enabled.
  - Auto-scan captures the first enabled channel at or after ptr, searching cyclically.
  - ptr then moves to that index+1 with wrap.
  - If ch_mask == 0: no capture, out_vld falls once the current word is accepted, and ptr holds.
  - In manual mode, a request for a masked channel pulses sel_err and does not capture.
- Without the macro: no ch_mask port; all channels are enabled.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_AUTO=1'b1 constants
  - clog2 helper function
  - default N_CH/DW constants
- Natural sub-module: mux_next_ch, a combinational cyclic priority finder (ptr, mask) -> (next_idx, found). It is used only under MUX_SCAN_MASK_EN; otherwise a plain wrap increment is used.

Test Plan:
1. Reset mid-stream: auto mode running, assert rst_n=0 asynchronously between edges -> outputs go to 0 immediately; after release, first word out_ch=0.
2. Manual, N_CH=8, DW=8, lane k=8'hA0+k, sel=5, sel_vld=1, out_rdy=1 -> next cycle out_data=8'hA5, out_ch=5, out_vld=1.
3. Backpressure: out_vld=1, out_rdy=0 for 4 cycles while lane data changes -> out_data and out_ch unchanged; first cycle with out_rdy=1 accepts.
4. Auto wrap, N_CH=6, out_rdy=1 for 14 cycles -> out_ch sequence 0,1,2,3,4,5,0,1,..., never 6 or 7.
5. Manual sel=6 with N_CH=6 -> sel_err single pulse, no capture, out_vld=0.
6. MUX_SCAN_MASK_EN, ch_mask=8'b1001_0010 -> out_ch cycles 1,4,7,1,...; ch_mask=0 -> out_vld drops after the last accept.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_scan_reg channel sampler.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    localparam int N_CH_DEFAULT = 8;
    localparam int DW_DEFAULT   = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Cyclic priority finder: first enabled channel at or after ptr.
// Only built when MUX_SCAN_MASK_EN is defined.
`ifdef MUX_SCAN_MASK_EN
module mux_next_ch #(
    parameter int N_CH = 8,
    parameter int SELW = 3
) (
    input  logic [SELW-1:0] ptr,
    input  logic [N_CH-1:0] mask,
    output logic [SELW-1:0] next_idx,
    output logic            found
);

    int unsigned j;

    always_comb begin
        found    = 1'b0;
        next_idx = ptr;
        j        = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= N_CH) j = j - N_CH;
            if (!found && mask[j]) begin
                found    = 1'b1;
                next_idx = SELW'(j);
            end
        end
    end

endmodule
`endif

// File: rtl/mux_scan_reg.sv
// Registered N-channel mux with valid/ready output, manual and auto-scan modes.
// Optional channel masking is enabled with MUX_SCAN_MASK_EN.
module mux_scan_reg
    import mux_pkg::*;
#(
    parameter  int N_CH = N_CH_DEFAULT,
    parameter  int DW   = DW_DEFAULT,
    localparam int SELW = clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    input  logic             sel_vld,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]  ch_mask,
`endif
    output logic [DW-1:0]    out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             sel_err
);

    logic [DW-1:0]   data_q, data_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            vld_q, vld_d;
    logic            err_q, err_d;
    mode_e           mode_q;

    logic            slot_free;
    logic            scan_hit;
    logic            sel_ok;
    logic            cap_en;
    logic [SELW-1:0] scan_base, scan_idx, cap_idx;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] p);
        return (int'(p) == N_CH - 1) ? '0 : p + 1'b1;
    endfunction

    assign slot_free = !vld_q || out_rdy;
    // A fresh entry into auto mode restarts the scan at channel 0.
    assign scan_base = (mode_q == MODE_AUTO) ? ptr_q : '0;

`ifdef MUX_SCAN_MASK_EN
    mux_next_ch #(
        .N_CH (N_CH),
        .SELW (SELW)
    ) u_next_ch (
        .ptr      (scan_base),
        .mask     (ch_mask),
        .next_idx (scan_idx),
        .found    (scan_hit)
    );
    assign sel_ok = (int'(sel) < N_CH) && ch_mask[sel];
`else
    assign scan_idx = scan_base;
    assign scan_hit = 1'b1;
    assign sel_ok   = (int'(sel) < N_CH);
`endif

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        cap_en  = 1'b0;
        cap_idx = scan_idx;
        if (mode == MODE_AUTO) begin
            ptr_d = scan_base;
            if (slot_free) begin
                if (scan_hit) begin
                    cap_en = 1'b1;
                    ptr_d  = wrap_inc(scan_idx);
                end else begin
                    vld_d = 1'b0;
                end
            end
        end else if (sel_vld && slot_free) begin
            if (sel_ok) begin
                cap_en  = 1'b1;
                cap_idx = sel;
            end else begin
                err_d = 1'b1;
                vld_d = 1'b0;
            end
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
        if (cap_en) begin
            data_d = in_data[int'(cap_idx)*DW +: DW];
            ch_d   = cap_idx;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ch_q   <= '0;
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            mode_q <= MODE_MANUAL;
        end else begin
            data_q <= data_d;
            ch_q   <= ch_d;
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            mode_q <= mode_e'(mode);
        end
    end

    assign out_data = data_q;
    assign out_ch   = ch_q;
    assign out_vld  = vld_q;
    assign sel_err  = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Randomized self-checking bench for mux_scan_reg (N_CH=6, DW=8) against a
// behavioural model; mask tests run when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_reg;

    localparam int N    = 6;
    localparam int DW   = 8;
    localparam int SELW = 3;

    logic              clk;
    logic              rst_n;
    logic [N*DW-1:0]   in_data;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic              sel_vld;
    logic [N-1:0]      mask_v;
    logic [DW-1:0]     out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_vld;
    logic              out_rdy;
    logic              sel_err;

    int checks;
    int errors;

    // reference model state
    int  m_data, m_ch, m_ptr;
    bit  m_vld, m_err, m_mode_q;

    mux_scan_reg #(
        .N_CH (N),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .mode     (mode),
        .sel      (sel),
        .sel_vld  (sel_vld),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask  (mask_v),
`endif
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lane(input int k);
        logic [N*DW-1:0] v;
        v = in_data;
        return int'(v[k*DW +: DW]);
    endfunction

    function automatic bit enabled(input int k);
        if (k >= N) return 1'b0;
`ifdef MUX_SCAN_MASK_EN
        return mask_v[k];
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_data = 0; m_ch = 0; m_ptr = 0;
        m_vld = 0; m_err = 0; m_mode_q = 0;
    endtask

    // Next model state from the inputs present at the coming edge.
    task automatic model_edge();
        bit free, hit;
        int base, c;
        free  = !m_vld || out_rdy;
        m_err = 0;
        if (mode) begin
            base = m_mode_q ? m_ptr : 0;
            hit  = 0;
            c    = base;
            for (int k = 0; k < N; k++) begin
                if (!hit && enabled((base + k) % N)) begin
                    hit = 1;
                    c   = (base + k) % N;
                end
            end
            m_ptr = base;
            if (free) begin
                if (hit) begin
                    m_data = lane(c); m_ch = c; m_vld = 1;
                    m_ptr  = (c + 1) % N;
                end else begin
                    m_vld = 0;
                end
            end
        end else if (sel_vld && free) begin
            if (enabled(int'(sel))) begin
                m_data = lane(int'(sel)); m_ch = int'(sel); m_vld = 1;
            end else begin
                m_err = 1; m_vld = 0;
            end
        end else if (out_rdy) begin
            m_vld = 0;
        end
        m_mode_q = mode;
    endtask

    task automatic compare_model();
        check("vld",  32'(out_vld),  32'(m_vld));
        check("ch",   32'(out_ch),   32'(m_ch));
        check("data", 32'(out_data), 32'(m_data));
        check("err",  32'(sel_err),  32'(m_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = 8'hA0 + 8'(k);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; mode = 1'b0; sel = '0; sel_vld = 1'b0; out_rdy = 1'b0;
        mask_v = '1; in_data = '0;
        model_reset();
        #2;
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_err", 32'(sel_err), 32'd0);
        #10 rst_n = 1'b1;

        // manual capture of lane 5
        set_ramp();
        sel = 3'd5; sel_vld = 1'b1; out_rdy = 1'b1;
        step();
        check("man_data", 32'(out_data), 32'hA5);
        check("man_ch",   32'(out_ch),   32'd5);
        check("man_vld",  32'(out_vld),  32'd1);

        // backpressure: word must hold while lanes change
        sel_vld = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            step();
            check("bp_data", 32'(out_data), 32'hA5);
            check("bp_ch",   32'(out_ch),   32'd5);
        end
        out_rdy = 1'b1;
        step();
        check("bp_accept", 32'(out_vld), 32'd0);

        // auto scan wraps at N-1
        set_ramp();
        mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            check("wrap_ch",   32'(out_ch),   32'(i % N));
            check("wrap_data", 32'(out_data), 32'(8'hA0 + 8'(i % N)));
        end

        // async reset mid-stream
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_vld",  32'(out_vld),  32'd0);
        check("arst_ch",   32'(out_ch),   32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        check("arst_hold", 32'(out_vld), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("arst_first", 32'(out_ch), 32'd0);
        step();
        check("arst_second", 32'(out_ch), 32'd1);

        // out-of-range manual select
        mode = 1'b0; sel = 3'd6; sel_vld = 1'b1; out_rdy = 1'b1;
        step();
        check("selerr_pulse", 32'(sel_err), 32'd1);
        check("selerr_vld",   32'(out_vld), 32'd0);
        sel_vld = 1'b0;
        step();
        check("selerr_clr", 32'(sel_err), 32'd0);

`ifdef MUX_SCAN_MASK_EN
        mask_v = 6'b10_0010;
        mode = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mask_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd5);
        end
        mask_v = '0;
        step();
        check("mask_zero_vld", 32'(out_vld), 32'd0);
        mask_v = 6'b00_1000;
        mode = 1'b0; sel = 3'd1; sel_vld = 1'b1;
        step();
        check("mask_man_err", 32'(sel_err), 32'd1);
`endif

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            out_rdy = ($urandom_range(0, 3) != 0);
            sel_vld = $urandom_range(0, 1);
            sel     = SELW'($urandom_range(0, 7));
            in_data = {$urandom, $urandom};
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 7) == 0)
                mask_v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
